// File: rtl/axi_chan_pkg.sv
// Shared types and elaboration-time helpers for the AXI channel buffer.
package axi_chan_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef logic [DEFAULT_WIDTH-1:0] beat_t;

  // Encoded as {pop, push} so the handshake pair casts straight into it.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int unsigned clog2_depth(input int unsigned depth);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < depth) r = r + 1;
    return r;
  endfunction

  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit af_thresh_ok(input int unsigned thresh, input int unsigned depth);
    return (thresh >= 1) && (thresh <= depth);
  endfunction

endpackage

// File: rtl/axi_chan_ptr.sv
// Wrapping FIFO pointer; width chosen so DEPTH-1 -> 0 wraps naturally.
module axi_chan_ptr #(
  parameter int unsigned PW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/axi_chan_fifo.sv
// VALID/READY channel buffer with occupancy, almost-full and synchronous flush.
module axi_chan_fifo
  import axi_chan_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AF_THRESH = 3
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int unsigned PW = clog2_depth(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [WIDTH-1:0] fifo_beat_t;

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("axi_chan_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (!af_thresh_ok(AF_THRESH, DEPTH)) begin : g_bad_af
    $error("axi_chan_fifo: AF_THRESH must be in 1..DEPTH");
  end

  fifo_beat_t       mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             ready_q;
  logic             push;
  logic             pop;
  fifo_op_e         op;

  // ready_q holds s_ready low through reset; flush keeps it high even when full.
  assign s_ready     = ready_q & ((count_q != CW'(DEPTH)) | flush);
  assign m_valid     = (count_q != '0);
  assign m_data      = m_valid ? mem[rd_ptr] : '0;
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AF_THRESH));

  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;
  assign op   = fifo_op_e'({pop, push});

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      case (op)
        OP_PUSH: count_q <= count_q + 1'b1;
        OP_POP:  count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (push && !flush) mem[wr_ptr] <= s_data;
  end

  axi_chan_ptr #(.PW(PW)) u_wr_ptr (
    .clk (ACLK),
    .rst (ARESET),
    .inc (push & ~flush),
    .clr (flush),
    .ptr (wr_ptr)
  );

  axi_chan_ptr #(.PW(PW)) u_rd_ptr (
    .clk (ACLK),
    .rst (ARESET),
    .inc (pop & ~flush),
    .clr (flush),
    .ptr (rd_ptr)
  );

endmodule
